// File: rtl/corg_pkg.sv
// ---------------------------------------------------------------------------
// corg_pkg
// Shared definitions for the CORG ALU issue controller:
//   - ALU opcode encodings (OP_ADD..OP_SLT, OP_ILL marks a rejected opcode)
//   - FSM state encoding
//   - instruction field bit positions and a field-decode helper
//   - 6-bit to 16-bit sign-extension helper
// ---------------------------------------------------------------------------
package corg_pkg;

    localparam int DW   = 16;  // data / instruction width (fixed)
    localparam int NREG = 8;   // register count (fixed)
    localparam int RW   = 3;   // register index width

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    // Instruction field positions.
    localparam int OP_MSB      = 15;
    localparam int OP_LSB      = 13;
    localparam int RD_MSB      = 12;
    localparam int RD_LSB      = 10;
    localparam int RS_MSB      = 9;
    localparam int RS_LSB      = 7;
    localparam int IMM_SEL_BIT = 6;
    localparam int RT_MSB      = 5;
    localparam int RT_LSB      = 3;
    localparam int IMM_MSB     = 5;
    localparam int IMM_LSB     = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    // rt and imm6 overlap in the instruction word; imm_sel picks which one is used.
    typedef struct packed {
        logic [2:0]    op;
        logic [RW-1:0] rd;
        logic [RW-1:0] rs;
        logic          imm_sel;
        logic [RW-1:0] rt;
        logic [5:0]    imm6;
    } instr_fields_t;

    function automatic instr_fields_t decode_instr(input logic [DW-1:0] w);
        instr_fields_t f;
        f.op      = w[OP_MSB:OP_LSB];
        f.rd      = w[RD_MSB:RD_LSB];
        f.rs      = w[RS_MSB:RS_LSB];
        f.imm_sel = w[IMM_SEL_BIT];
        f.rt      = w[RT_MSB:RT_LSB];
        f.imm6    = w[IMM_MSB:IMM_LSB];
        return f;
    endfunction

    function automatic logic [DW-1:0] sext6(input logic [5:0] imm);
        return {{(DW-6){imm[5]}}, imm};
    endfunction

endpackage

// File: rtl/corg_regfile.sv
// ---------------------------------------------------------------------------
// corg_regfile
// 8 x 16 register file, R0 hard-wired to zero.
//   clk, rst_n          : clock, synchronous active-low clear of all registers
//   we, waddr, wdata    : synchronous write port (writes to R0 are discarded)
//   raddr_a / rdata_a   : combinational read port A
//   raddr_b / rdata_b   : combinational read port B
//   dbg_addr / dbg_data : combinational debug read port
// ---------------------------------------------------------------------------
module corg_regfile
    import corg_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [RW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [RW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [RW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [RW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];

    always_comb begin
        // NOTE: start from the held value so every path assigns regs_d; a
        // missing default here would infer latches.
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
        // R0 stays zero regardless of writes, so reads need no special case.
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: this storage is cleared on reset because software relies on
        // all registers reading zero afterwards; that keeps it in flops
        // rather than a RAM macro, which cannot be reset.
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            regs_q <= regs_d;
        end
    end

    assign rdata_a  = regs_q[raddr_a];
    assign rdata_b  = regs_q[raddr_b];
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Serialised issue controller for an external 16-bit ALU. One instruction in
// flight: IDLE -> DECODE -> EXEC -> WB -> IDLE (illegal: IDLE -> DECODE -> IDLE).
//   clk, rst_n               : clock, synchronous active-low reset
//   instr_valid/instr_ready  : instruction handshake (ready only in IDLE)
//   instr                    : [15:13] op [12:10] rd [9:7] rs [6] imm_sel
//                              [5:3] rt / [5:0] imm6
//   alu_op, alu_a, alu_b     : registered ALU controls, held outside DECODE
//   alu_result               : combinational ALU result
//   wb_valid, wb_rd, wb_data : one-cycle write-back pulse and its payload
//   illegal                  : one-cycle pulse while decoding op 111
//   dbg_addr / dbg_data      : combinational debug register read
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import corg_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [DW-1:0] instr,
    output logic [2:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    output logic          wb_valid,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          illegal,
    input  logic [RW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    state_e        state_q,  state_d;
    logic [DW-1:0] ir_q,     ir_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic [DW-1:0] alu_a_q,  alu_a_d;
    logic [DW-1:0] alu_b_q,  alu_b_d;
    logic [DW-1:0] result_q, result_d;

    instr_fields_t ir_f;
    logic [DW-1:0] rf_rdata_a;
    logic [DW-1:0] rf_rdata_b;
    logic          rf_we;

    assign ir_f = decode_instr(ir_q);

    // Write happens at the end of WB, so the following DECODE (at least two
    // cycles later) always reads the updated value: no hazard logic needed.
    assign rf_we = (state_q == ST_WB);

    corg_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (ir_f.rd),
        .wdata    (result_q),
        .raddr_a  (ir_f.rs),
        .rdata_a  (rf_rdata_a),
        .raddr_b  (ir_f.rt),
        .rdata_b  (rf_rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (ir_f.op == OP_ILL) begin
                    // Rejected: ALU controls keep their previous values.
                    state_d = ST_IDLE;
                end else begin
                    alu_op_d = ir_f.op;
                    alu_a_d  = rf_rdata_a;
                    alu_b_d  = ir_f.imm_sel ? sext6(ir_f.imm6) : rf_rdata_b;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                state_d  = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            alu_op_q <= OP_ADD;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            result_q <= result_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign illegal     = (state_q == ST_DECODE) && (ir_f.op == OP_ILL);
    assign wb_valid    = (state_q == ST_WB);
    // Payload is zeroed outside the pulse so idle cycles show no stale data.
    assign wb_rd       = wb_valid ? ir_f.rd  : '0;
    assign wb_data     = wb_valid ? result_q : '0;

    assign alu_op = alu_op_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Drives alu_issue_ctrl together with a behavioural ALU, checks handshake
// timing, write-back contents and register state against an integer
// architectural model of the instruction set.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        illegal;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_cmp = 0;
    int n_mis = 0;

    // Architectural register state as the instruction set defines it.
    logic [15:0] ref_regs [8];

    always #10 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // External ALU.
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a & alu_b;
            3'b010:  alu_result = alu_a - alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = alu_a << alu_b[3:0];
            3'b110:  alu_result = {15'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 16'd0;
        endcase
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    // Expected ALU result from integer arithmetic, reduced modulo 2^16.
    function automatic logic [15:0] model_op(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = (a + b) % 65536;
            1:       r = a & b;
            2:       r = (a - b + 65536) % 65536;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = (a * (1 << (b % 16))) % 65536;
            6:       r = (to_signed16(a) < to_signed16(b)) ? 1 : 0;
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    function automatic logic [15:0] model_imm(input int imm6);
        int v;
        v = (imm6 >= 32) ? imm6 - 64 : imm6;
        return 16'((v + 65536) % 65536);
    endfunction

    function automatic logic [15:0] enc(input int op, input int rd, input int rs,
                                       input int imm_sel, input int low6);
        return 16'((op << 13) | (rd << 10) | (rs << 7) | (imm_sel << 6) | (low6 & 63));
    endfunction

    // Called at a negedge; all reads finish before the next posedge.
    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), dbg_data, ref_regs[i]);
        end
    endtask

    task automatic check_reg_const(input string tag, input int idx, input logic [15:0] val);
        dbg_addr = 3'(idx);
        #1;
        check(tag, dbg_data, val);
    endtask

    // Issue one instruction and follow it cycle by cycle to completion.
    task automatic do_instr(input logic [15:0] w);
        int op, rd, rs, rt, sel, imm;
        logic [15:0] a, b, exp;
        op  = int'(w[15:13]);
        rd  = int'(w[12:10]);
        rs  = int'(w[9:7]);
        sel = int'(w[6]);
        rt  = int'(w[5:3]);
        imm = int'(w[5:0]);
        a   = ref_regs[rs];
        b   = (sel != 0) ? model_imm(imm) : ref_regs[rt];
        exp = model_op(op, int'(a), int'(b));

        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        check("ready_idle", 16'(instr_ready), 16'd1);

        @(negedge clk);                      // DECODE
        instr_valid = 1'b0;
        check("illegal_decode", 16'(illegal), (op == 7) ? 16'd1 : 16'd0);
        check("wb_decode", 16'(wb_valid), 16'd0);
        check("ready_decode", 16'(instr_ready), 16'd0);

        @(negedge clk);
        if (op == 7) begin                   // back in IDLE
            check("ready_after_ill", 16'(instr_ready), 16'd1);
            check("illegal_after", 16'(illegal), 16'd0);
            check("wb_after_ill", 16'(wb_valid), 16'd0);
            check_regs("ill_regs");
            return;
        end
        check("alu_op", 16'(alu_op), 16'(op));  // EXEC
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
        check("wb_exec", 16'(wb_valid), 16'd0);

        @(negedge clk);                      // WB
        check("wb_valid", 16'(wb_valid), 16'd1);
        check("wb_rd", 16'(wb_rd), 16'(rd));
        check("wb_data", wb_data, exp);
        if (rd != 0) ref_regs[rd] = exp;

        @(negedge clk);                      // IDLE again
        check("wb_idle", 16'(wb_valid), 16'd0);
        check("ready_ret", 16'(instr_ready), 16'd1);
        check("alu_a_hold", alu_a, a);
        dbg_addr = 3'(rd);
        #1;
        check("dbg_wb", dbg_data, ref_regs[rd]);
    endtask

    initial begin
        int accepts, wbs;
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'd0;
        dbg_addr    = 3'd0;

        // T1: reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 16'(instr_ready), 16'd1);
        check("rst_wb", 16'(wb_valid), 16'd0);
        check("rst_illegal", 16'(illegal), 16'd0);
        check("rst_alu_op", 16'(alu_op), 16'd0);
        check("rst_alu_a", alu_a, 16'd0);
        check("rst_alu_b", alu_b, 16'd0);
        rst_n = 1'b1;
        check_regs("rst_regs");

        // T2: ADDI r1,r0,#21.
        do_instr(16'h0455);
        check_reg_const("t2_r1", 1, 16'h0015);

        // T3: immediate sign extension, sub, shift, self-xor.
        do_instr(enc(0, 2, 0, 1, 6'h3D));    // ADDI r2,r0,#-3
        check_reg_const("t3_r2", 2, 16'hFFFD);
        do_instr(enc(2, 3, 1, 0, 2 << 3));   // SUB r3,r1,r2
        check_reg_const("t3_r3", 3, 16'h0018);
        do_instr(enc(5, 5, 1, 1, 3));        // SLL r5,r1,#3
        check_reg_const("t3_r5", 5, 16'h00A8);
        do_instr(enc(4, 6, 1, 0, 1 << 3));   // XOR r6,r1,r1
        check_reg_const("t3_r6", 6, 16'h0000);

        // T4: illegal opcode.
        do_instr(enc(7, 3, 1, 0, 0));

        // T5: write to R0 is discarded but still pulses.
        do_instr(enc(0, 0, 0, 1, 5));
        check_reg_const("t5_r0", 0, 16'h0000);

        // T5: valid held high continuously -> one accept per four cycles.
        @(negedge clk);
        instr       = enc(0, 4, 0, 1, 7);    // ADDI r4,r0,#7
        instr_valid = 1'b1;
        accepts     = 0;
        wbs         = 0;
        for (int c = 0; c < 16; c++) begin
            if (instr_valid && instr_ready) accepts++;
            if (wb_valid) begin
                wbs++;
                check("stream_wb_data", wb_data, 16'h0007);
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        ref_regs[4] = 16'h0007;
        check("stream_accepts", 16'(accepts), 16'd4);
        check("stream_wbs", 16'(wbs), 16'd4);
        check_regs("stream_regs");

        // Randomised instruction mix, including illegal opcodes.
        for (int n = 0; n < 40; n++) begin
            do_instr(enc(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                         int'($urandom_range(0, 63))));
        end
        check_regs("rand_regs");

        // T6: reset during EXEC of ADDI r7,r0,#9 aborts the instruction.
        @(negedge clk);
        instr       = enc(0, 7, 0, 1, 9);
        instr_valid = 1'b1;
        @(negedge clk);                      // DECODE
        instr_valid = 1'b0;
        @(negedge clk);                      // EXEC
        check("t6_alu_b", alu_b, 16'h0009);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_wb", 16'(wb_valid), 16'd0);
        check("t6_ready", 16'(instr_ready), 16'd1);
        check("t6_illegal", 16'(illegal), 16'd0);
        check("t6_alu_op", 16'(alu_op), 16'd0);
        check("t6_alu_a", alu_a, 16'd0);
        check("t6_alu_b_rst", alu_b, 16'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'd0;
        check_regs("t6_regs");
        @(negedge clk);
        check("t6_wb_after", 16'(wb_valid), 16'd0);
        check_reg_const("t6_r7", 7, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
